// File: rtl/tanhx4_hw.sv
// Sequential binary32 tanh(x) using a 4-level Lambert continued fraction and a restoring divider.
// Optional build macro TANHX_ROUND_EN: round-to-nearest-even in PACK instead of truncation.
module tanhx4_hw #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] x_in,
    output logic [DWIDTH-1:0] y_out,
    output logic              valid
);

    localparam int unsigned AW        = 24;  // |x| as Q2.22
    localparam int unsigned A2W       = 26;  // a^2 as Q4.22
    localparam int unsigned PW        = 34;  // num/den as Q12.22
    localparam int unsigned QW        = 26;  // quotient fraction bits
    localparam int unsigned DIV_STEPS = 25;  // last quotient bit resolved in PACK
    localparam logic [PW-1:0] K105    = PW'(105) << 22;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLASS = 3'd1;
    localparam logic [2:0] S_SQ    = 3'd2;
    localparam logic [2:0] S_POLY  = 3'd3;
    localparam logic [2:0] S_DIV   = 3'd4;
    localparam logic [2:0] S_PACK  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [1:0] C_NORM = 2'd0;
    localparam logic [1:0] C_TINY = 2'd1;
    localparam logic [1:0] C_SAT  = 2'd2;
    localparam logic [1:0] C_NAN  = 2'd3;

    logic [2:0]        state, state_nx;
    logic [DWIDTH-1:0] x_reg;
    logic [1:0]        cls, cls_c;
    logic [AW-1:0]     a, a_c;
    logic [A2W-1:0]    a2, a2_c;
    logic [PW-1:0]     rem, den, num_c, den_c, rem_nx;
    logic [QW-2:0]     quo;
    logic [4:0]        cnt;
    logic              q_bit;
    logic [DWIDTH-1:0] y_pack;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_CLASS;
            S_CLASS: state_nx = S_SQ;
            S_SQ:    state_nx = S_POLY;
            S_POLY:  state_nx = S_DIV;
            S_DIV:   if (cnt == 5'(DIV_STEPS - 1)) state_nx = S_PACK;
            S_PACK:  state_nx = S_DONE;
            S_DONE:  if (!start) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Classification and |x| -> Q2.22 conversion
    always_comb begin
        logic [7:0]  e;
        logic [22:0] m;
        e     = x_reg[30:23];
        m     = x_reg[22:0];
        cls_c = C_NORM;
        if (e == 8'd255 && m != 23'd0)                   cls_c = C_NAN;
        else if (e > 8'd128 || (e == 8'd128 && m[22]))   cls_c = C_SAT;
        else if (e < 8'd115)                             cls_c = C_TINY;
        if (e >= 8'd128) a_c = {1'b1, m};
        else             a_c = {1'b1, m} >> (8'd128 - e);
    end

    // Square and polynomial terms
    always_comb begin
        logic [2*AW-1:0]     sq_full;
        logic [AW+PW-1:0]    num_full;
        logic [2*A2W-1:0]    a4_full;
        logic [PW-1:0]       t1;
        sq_full  = (2*AW)'(a) * (2*AW)'(a);
        a2_c     = A2W'(sq_full >> 22);
        t1       = K105 + PW'(a2) * PW'(10);
        num_full = (AW+PW)'(a) * (AW+PW)'(t1);
        num_c    = PW'(num_full >> 22);
        a4_full  = (2*A2W)'(a2) * (2*A2W)'(a2);
        den_c    = K105 + PW'(a2) * PW'(45) + PW'(a4_full >> 22);
    end

    // One restoring-division step
    always_comb begin
        logic [PW:0] rem_sh;
        rem_sh = {rem, 1'b0};
        q_bit  = (rem_sh >= {1'b0, den});
        rem_nx = q_bit ? PW'(rem_sh - {1'b0, den}) : PW'(rem_sh);
    end

    // Normalize the quotient and apply the special-class overrides
    always_comb begin
        logic [QW-1:0] q, qn;
        logic [4:0]    lead;
        logic [7:0]    ex;
        logic [30:0]   mag;
        logic          guard, sticky;
        q    = {quo, q_bit};
        lead = 5'd0;
        for (int i = 0; i < int'(QW); i++) begin
            if (q[i]) lead = 5'(i);
        end
        qn     = q << (5'(QW - 1) - lead);
        ex     = 8'(lead) + 8'd101;
        guard  = qn[1];
        sticky = qn[0] | (|rem_nx);
        mag    = (q == '0) ? 31'd0 : {ex, qn[24:2]};
`ifdef TANHX_ROUND_EN
        if (q != '0 && guard && (sticky || mag[0])) mag = mag + 31'd1;
`else
        if (guard && sticky) mag = mag;
`endif
        case (cls)
            C_NAN:   y_pack = 32'h7FC0_0000;
            C_SAT:   y_pack = {x_reg[31], 8'd127, 23'd0};
            C_TINY:  y_pack = x_reg;
            default: y_pack = {x_reg[31], mag};
        endcase
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg <= '0;
            cls   <= C_NORM;
            a     <= '0;
            a2    <= '0;
            rem   <= '0;
            den   <= '0;
            quo   <= '0;
            cnt   <= '0;
            y_out <= '0;
            valid <= 1'b0;
        end else begin
            valid <= (state_nx == S_DONE);
            case (state)
                S_IDLE:  if (start) x_reg <= x_in;
                S_CLASS: begin
                    cls <= cls_c;
                    a   <= a_c;
                end
                S_SQ:    a2 <= a2_c;
                S_POLY: begin
                    rem <= num_c;
                    den <= den_c;
                    quo <= '0;
                    cnt <= '0;
                end
                S_DIV: begin
                    rem <= rem_nx;
                    quo <= {quo[QW-3:0], q_bit};
                    cnt <= cnt + 5'd1;
                end
                S_PACK:  y_out <= y_pack;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tanhx4_hw.sv
// Table-driven bench for tanhx4_hw: expected results are queued at start and checked when valid rises.
module tb_tanhx4_hw;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x_in;
    logic [31:0] y_out;
    logic        valid;

    always #5 clk = ~clk;

    tanhx4_hw #(.DWIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x_in  (x_in),
        .y_out (y_out),
        .valid (valid)
    );

    typedef struct {
        logic [31:0] x;
        bit          exact;
        logic [31:0] y;
        real         yr;
        real         tol;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic real f2r(input logic [31:0] b);
        real r;
        int  e;
        int  mi;
        mi = int'({9'd0, b[22:0]});
        e  = int'({24'd0, b[30:23]});
        if (e == 0) begin
            r = real'(mi) / 8388608.0;
            e = 1;
        end else begin
            r = 1.0 + real'(mi) / 8388608.0;
        end
        for (int i = 127; i < e; i++) r = r * 2.0;
        for (int i = e; i < 127; i++) r = r * 0.5;
        return b[31] ? -r : r;
    endfunction

    task automatic check_bits(input bit ok, input string what, input logic [31:0] got,
                              input logic [31:0] want);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", what, got, want);
        end
    endtask

    task automatic check_result(input vec_t e, input int idx);
        real yr, d;
        n_vec++;
        if (e.exact) begin
            if (y_out !== e.y) begin
                n_bad++;
                $display("FAIL vec%0d x=%h: got %h required %h", idx, e.x, y_out, e.y);
            end
        end else begin
            yr = f2r(y_out);
            d  = yr - e.yr;
            if (d < 0.0) d = -d;
            if (d > e.tol || $isunknown(y_out)) begin
                n_bad++;
                $display("FAIL vec%0d x=%h: got %h (%f) required %f +- %g", idx, e.x, y_out, yr,
                         e.yr, e.tol);
            end
        end
    endtask

    // Start one operation, check latency and result, then release start
    task automatic run_op(input vec_t v, input int idx, input int hold);
        int   lat;
        vec_t e;
        @(negedge clk);
        x_in  = v.x;
        start = 1'b1;
        sb.push_back(v);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = k;
                break;
            end
        end
        check_bits(lat == 30, $sformatf("latency vec%0d", idx), 32'(lat), 32'd30);
        e = sb.pop_front();
        if (lat != 0) check_result(e, idx);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            x_in = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_bits(valid == 1'b0, $sformatf("valid_fall vec%0d", idx), {31'd0, valid}, 32'd0);
    endtask

    initial begin
        bit   ok;
        vec_t v;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
        v = '{32'h0, 1'b0, 32'h0, 0.0, 0.0};
        ok = 1'b0;
    end

    initial begin
        bit ok;
        vecs.push_back('{32'h3F9D70A4, 1'b0, 32'h0, 0.842579, 1.0e-4});   // 1.23
        vecs.push_back('{32'h3F19999A, 1'b0, 32'h0, 0.537050, 1.0e-4});   // 0.6
        vecs.push_back('{32'h4007AE14, 1'b0, 32'h0, 0.971600, 6.0e-3});   // 2.12
        vecs.push_back('{32'hC0133333, 1'b0, 32'h0, -0.980096, 6.0e-3});  // -2.3
        vecs.push_back('{32'h40B0F5C3, 1'b1, 32'h3F800000, 0.0, 0.0});    // 5.53
        vecs.push_back('{32'hC12A48C0, 1'b1, 32'hBF800000, 0.0, 0.0});    // -10.6428
        vecs.push_back('{32'h7F800000, 1'b1, 32'h3F800000, 0.0, 0.0});    // +inf
        vecs.push_back('{32'hFF800000, 1'b1, 32'hBF800000, 0.0, 0.0});    // -inf
        vecs.push_back('{32'h7FC80000, 1'b1, 32'h7FC00000, 0.0, 0.0});    // NaN
        vecs.push_back('{32'hFFC00001, 1'b1, 32'h7FC00000, 0.0, 0.0});    // -NaN
        vecs.push_back('{32'h00000000, 1'b1, 32'h00000000, 0.0, 0.0});    // +0
        vecs.push_back('{32'h80000000, 1'b1, 32'h80000000, 0.0, 0.0});    // -0
        vecs.push_back('{32'h00480000, 1'b1, 32'h00480000, 0.0, 0.0});    // denormal
        vecs.push_back('{32'h39000000, 1'b1, 32'h39000000, 0.0, 0.0});    // 2^-13, tiny edge
        vecs.push_back('{32'h39800000, 1'b0, 32'h0, 2.441406e-4, 1.0e-6});// 2^-12, first normal
        vecs.push_back('{32'h3DE32510, 1'b0, 32'h0, 0.110457, 1.0e-4});   // 0.11091
        vecs.push_back('{32'h3F800000, 1'b0, 32'h0, 0.761594, 1.0e-4});   // 1.0
        vecs.push_back('{32'hBF800000, 1'b0, 32'h0, -0.761594, 1.0e-4});  // -1.0
        vecs.push_back('{32'h4039999A, 1'b0, 32'h0, 0.993963, 6.0e-3});   // 2.9
        vecs.push_back('{32'h40400000, 1'b1, 32'h3F800000, 0.0, 0.0});    // 3.0 saturates
        vecs.push_back('{32'hC0400000, 1'b1, 32'hBF800000, 0.0, 0.0});    // -3.0

        rst   = 1'b1;
        start = 1'b0;
        x_in  = 32'h0;
        @(posedge clk);
        #1;
        check_bits(valid == 1'b0, "reset_valid", {31'd0, valid}, 32'd0);
        check_bits(y_out == 32'h0, "reset_y", y_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b0) ok = 1'b0;
        end
        check_bits(ok, "idle_no_valid", {31'd0, ~ok}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], i, 1);

        // Held start after valid: x_in changes must not disturb the result
        @(negedge clk);
        x_in  = 32'h7F800000;
        start = 1'b1;
        sb.push_back('{32'h7F800000, 1'b1, 32'h3F800000, 0.0, 0.0});
        repeat (30) @(posedge clk);
        #1;
        check_bits(valid == 1'b1, "hold_valid_rise", {31'd0, valid}, 32'd1);
        check_result(sb.pop_front(), 100);
        ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            x_in = (k % 2 == 0) ? 32'h3F19999A : $urandom;
            @(posedge clk);
            #1;
            if (valid !== 1'b1 || y_out !== 32'h3F800000) ok = 1'b0;
        end
        check_bits(ok, "hold_stable", y_out, 32'h3F800000);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_bits(valid == 1'b0, "hold_release", {31'd0, valid}, 32'd0);

        // Reset while the divider is running aborts the operation
        @(negedge clk);
        x_in  = 32'h3F9D70A4;
        start = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b0) ok = 1'b0;
        end
        check_bits(ok, "abort_no_valid", {31'd0, ~ok}, 32'd0);
        check_bits(y_out == 32'h0, "abort_y_cleared", y_out, 32'h0);

        run_op(vecs[1], 200, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
